// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection arbiter.
//   credit_width(depth) : width of a credit counter that holds 0..depth
//   arb_state_e         : arbiter state (free to pick / locked to one packet)
package noc_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Bundle between the local traffic sources, the injection arbiter and the
// router input port.
//   slave  : arbiter side (takes source flits and credits, drives router)
//   master : environment side (sources + router)
// Signals:
//   src_data/src_dest/src_is_tail/src_valid : per-source flit offer
//   src_ready                               : per-source accept
//   data_out/dest_out/is_tail_out/send_out  : registered flit to router
//   credit_in                               : returned router buffer slot
//   credit_overflow                         : sticky credit overflow flag
interface noc_inject_arbiter_if #(
    parameter int NUM_SOURCES = 4,
    parameter int FLIT_WIDTH  = 256,
    parameter int DEST_WIDTH  = 3
);
    logic [NUM_SOURCES-1:0][FLIT_WIDTH-1:0] src_data;
    logic [NUM_SOURCES-1:0][DEST_WIDTH-1:0] src_dest;
    logic [NUM_SOURCES-1:0]                 src_is_tail;
    logic [NUM_SOURCES-1:0]                 src_valid;
    logic [NUM_SOURCES-1:0]                 src_ready;
    logic [FLIT_WIDTH-1:0]                  data_out;
    logic [DEST_WIDTH-1:0]                  dest_out;
    logic                                   is_tail_out;
    logic                                   send_out;
    logic                                   credit_in;
    logic                                   credit_overflow;

    modport slave (
        input  src_data, src_dest, src_is_tail, src_valid, credit_in,
        output src_ready, data_out, dest_out, is_tail_out, send_out,
               credit_overflow
    );

    modport master (
        output src_data, src_dest, src_is_tail, src_valid, credit_in,
        input  src_ready, data_out, dest_out, is_tail_out, send_out,
               credit_overflow
    );
endinterface

// File: rtl/noc_inject_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index for this pick
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted request
// The request vector is doubled so a single lowest-set-bit search starting
// at ptr naturally wraps past N-1 back to 0.
module rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [N-1:0]   mask_lo;
    logic [2*N-1:0] masked;
    logic           gnt_valid;

    // Lower copy keeps only positions at or above ptr; upper copy is the wrap.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign mask_lo[gi] = (ptr <= IW'(gi));
    end

    assign masked = {req, req & mask_lo};

    // Scan downward so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(i % N);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
        assign gnt[gi] = gnt_valid && (gnt_idx == IW'(gi));
    end
endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level (wormhole) injection arbiter sharing one router input port
// among NUM_SOURCES local sources, with downstream credit tracking.
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : source offers/accepts, registered router send stage, credits
// Once a non-tail flit is accepted, the arbiter stays locked to that source
// until its tail flit is accepted, so packets never interleave.
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_SOURCES       = 4,
    parameter int FLIT_WIDTH        = 256,
    parameter int DEST_WIDTH        = 3,
    parameter int FLIT_BUFFER_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    noc_inject_arbiter_if.slave  bus
);
    localparam int              IW      = $clog2(NUM_SOURCES);
    localparam int              CW      = credit_width(FLIT_BUFFER_DEPTH);
    localparam logic [CW-1:0]   CNT_MAX = CW'(FLIT_BUFFER_DEPTH);

    arb_state_e              state_reg, state_next;
    logic [IW-1:0]           rr_ptr_reg, owner_reg;
    logic [CW-1:0]           cnt_reg;
    logic [FLIT_WIDTH-1:0]   data_out_reg;
    logic [DEST_WIDTH-1:0]   dest_out_reg;
    logic                    is_tail_out_reg, send_out_reg, overflow_reg;

    logic [NUM_SOURCES-1:0]  pick_gnt, ready;
    logic [IW-1:0]           pick_idx, acc_idx, acc_idx_inc;
    logic                    has_credit, accept, acc_tail;

    rr_picker #(.N(NUM_SOURCES)) u_picker (
        .req     (bus.src_valid),
        .ptr     (rr_ptr_reg),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    // Ready looks only at the registered credit count; a credit arriving this
    // cycle becomes usable next cycle.
    assign has_credit  = (cnt_reg != '0);
    assign acc_idx     = (state_reg == ARB_IDLE) ? pick_idx : owner_reg;
    assign accept      = |(bus.src_valid & ready);
    assign acc_tail    = bus.src_is_tail[acc_idx];
    assign acc_idx_inc = (acc_idx == IW'(NUM_SOURCES - 1)) ? '0 : acc_idx + IW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= ARB_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:   if (accept && !acc_tail) state_next = ARB_LOCKED;
            ARB_LOCKED: if (accept && acc_tail)  state_next = ARB_IDLE;
            default:    state_next = ARB_IDLE;
        endcase
    end

    // Output logic: in LOCKED the owner is ready even while it is not valid,
    // which keeps every other source blocked during owner bubbles.
    always_comb begin
        ready = '0;
        if (rst_n && has_credit) begin
            if (state_reg == ARB_IDLE) ready = pick_gnt;
            else                       ready[owner_reg] = 1'b1;
        end
    end

    // Round-robin pointer and packet owner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
        end else if (accept) begin
            if (acc_tail)                      rr_ptr_reg <= acc_idx_inc;
            else if (state_reg == ARB_IDLE)    owner_reg  <= acc_idx;
        end
    end

    // Credit counter: one slot per sent flit, one back per credit_in.
    // A credit with the counter already full is a protocol error; the count
    // saturates and the sticky flag records it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg      <= CNT_MAX;
            overflow_reg <= 1'b0;
        end else begin
            case ({accept, bus.credit_in})
                2'b10:   cnt_reg <= cnt_reg - CW'(1);
                2'b01: begin
                    if (cnt_reg == CNT_MAX) overflow_reg <= 1'b1;
                    else                    cnt_reg      <= cnt_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered send stage; payload registers hold when nothing is sent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            send_out_reg    <= 1'b0;
            data_out_reg    <= '0;
            dest_out_reg    <= '0;
            is_tail_out_reg <= 1'b0;
        end else begin
            send_out_reg <= accept;
            if (accept) begin
                data_out_reg    <= bus.src_data[acc_idx];
                dest_out_reg    <= bus.src_dest[acc_idx];
                is_tail_out_reg <= acc_tail;
            end
        end
    end

    assign bus.src_ready       = ready;
    assign bus.send_out        = send_out_reg;
    assign bus.data_out        = data_out_reg;
    assign bus.dest_out        = dest_out_reg;
    assign bus.is_tail_out     = is_tail_out_reg;
    assign bus.credit_overflow = overflow_reg;
endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Packet-level arbiter that shares one router input port among NUM_SOURCES local traffic sources at a NoC endpoint. It picks a source round-robin and locks onto it from head to tail flit, so packets are never interleaved (wormhole). It tracks downstream buffer credits and drives the router's send/credit interface from a registered output stage.

## Interface
- NUM_SOURCES, 4, number of local requesters (≥2)
- FLIT_WIDTH, 256, flit payload width
- DEST_WIDTH, 3, destination id width
- FLIT_BUFFER_DEPTH, 2, router input buffer depth; initial credit count
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- src_data  in  [FLIT_WIDTH-1:0] [NUM_SOURCES]  per-source flit payload
- src_dest  in  [DEST_WIDTH-1:0] [NUM_SOURCES]  per-source destination, held constant within a packet
- src_is_tail  in  1 [NUM_SOURCES]  flit is last of packet
- src_valid  in  1 [NUM_SOURCES]  flit offered
- src_ready  out  1 [NUM_SOURCES]  flit accepted this cycle when valid & ready
- data_out  out  FLIT_WIDTH  to router data_in
- dest_out  out  DEST_WIDTH  to router dest_in
- is_tail_out  out  1  to router is_tail_in
- send_out  out  1  to router send_in; one flit per asserted cycle
- credit_in  in  1  from router credit_out; one returned buffer slot
- credit_overflow  out  1  sticky error: credit_in received while counter already at FLIT_BUFFER_DEPTH

## Operation
- Credit counter cnt, width $clog2(FLIT_BUFFER_DEPTH)+1, reset FLIT_BUFFER_DEPTH. Update: cnt <= cnt − accept + credit_in. On overflow, cnt saturates at FLIT_BUFFER_DEPTH and credit_overflow sets until reset.
- accept = |(src_valid & src_ready). At most one src_ready bit is high in any cycle.
- src_ready is combinational and requires cnt > 0 (registered value only; a same-cycle credit_in does not enable ready). It is forced to 0 while rst_n = 0.
- State machine:
  - IDLE: src_ready is the round-robin pick among src_valid, starting at rr_ptr and searching upward with wrap. No pick when cnt = 0.
    - Accept with src_is_tail=1 (single-flit packet): stay IDLE; rr_ptr <= pick+1 mod NUM_SOURCES.
    - Accept with tail=0: go to LOCKED; owner <= pick.
  - LOCKED: src_ready[owner] = cnt > 0; all other bits are 0.
    - Accepted tail: go to IDLE; rr_ptr <= owner+1 mod NUM_SOURCES.
    - Otherwise remain LOCKED, including an arbitrary number of idle cycles while the owner has src_valid=0.
- Output stage: on accept, register {data, dest, is_tail} from the accepted source and set send_out=1 next cycle. With no accept, send_out=0 and the data/dest/tail registers hold their last values.
- Reset values: state IDLE, rr_ptr 0, owner 0, cnt FLIT_BUFFER_DEPTH, send_out 0, data_out 0, dest_out 0, is_tail_out 0, credit_overflow 0.
- Reset mid-packet drops the in-progress packet and any staged flit. The router must be reset in the same cycle.

## Timing
- Latency: src handshake in cycle t → send_out high in cycle t+1.
- Throughput: 1 flit/cycle while cnt > 0.
- cnt = 0 with credit_in in cycle t → src_ready may rise at t+1.
- Accept and credit_in in the same cycle → cnt unchanged.
- cnt never goes below 0, so send_out is never issued without a credit.
- Round-robin fairness: with all sources continuously valid and sending single-flit packets, grant order is 0,1,2,…,N−1,0 with no source skipped.

## Structure
- Shared package noc_pkg holds:
  - function credit_width(depth) = $clog2(depth)+1
  - typedef enum {ARB_IDLE, ARB_LOCKED} for the state
- Sub-module rr_picker #(N): inputs req[N] and ptr; outputs a one-hot gnt and its binary index. Purely combinational, double-width mask-and-priority-encode.
- Top level contains the state register, rr_ptr, owner, credit counter, and output registers.

## Test plan
- Single source, DEPTH=2, credit_in held 0: source 0 streams a 4-flit packet → exactly 2 handshakes, send_out pulses at t+1 and t+2, then src_ready stays 0. Pulse credit_in once → one more flit is sent.
- All 4 sources valid with single-flit packets, credit_in returned every cycle → accept order 0,1,2,3,0,1.
- Source 1 sends a 3-flit packet while source 0 holds valid the whole time → source 1's flits are contiguous on send_out; source 0 is accepted only after source 1's tail. rr_ptr = 2 afterwards, so source 2 wins if it is valid.
- Owner drops src_valid for 5 cycles mid-packet while others are valid → no other source gets ready; the packet resumes and completes intact.
- Accept with simultaneous credit_in at cnt=1 → cnt stays 1. A spurious credit_in at cnt=2 → credit_overflow=1 and cnt stays 2.
- Assert rst_n=0 for 1 cycle in LOCKED mid-packet → the next cycle shows send_out=0 and cnt=2. After release, rr_ptr=0 and source 0 wins if it is valid.
